// File: rtl/seg7_pkg.sv
// Shared types and the BCD-to-segment decoder for the seven-segment display driver.
package seg7_pkg;

    // Refresh phases in frame order: ONES -> GAP1 -> TENS -> GAP0 -> ONES.
    typedef enum logic [1:0] {
        ONES = 2'd0,
        GAP1 = 2'd1,
        TENS = 2'd2,
        GAP0 = 2'd3
    } state_e;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Active-high decode; non-BCD codes show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] pattern;
        pattern = SEG_DASH;
        case (digit)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_mux_driver.sv
// Two-digit time-multiplexed seven-segment driver with blanking gaps and a per-frame
// snapshot of the displayed digits.
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter bit          LZ_BLANK    = 1'b1,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned MaxDwell = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int unsigned CntW     = $clog2(MaxDwell);

    localparam logic [CntW-1:0] LitLast = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);

    // Pin-level "dark" values for the selected polarity.
    localparam logic [6:0] SegDark = ACTIVE_LOW ? 7'h7F : SEG_OFF;
    localparam logic [1:0] AnDark  = ACTIVE_LOW ? 2'b11 : 2'b00;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      ones_q, ones_d;
    logic [3:0]      tens_q, tens_d;
    logic [6:0]      seg_q, seg_d;
    logic [1:0]      an_q, an_d;
    logic            dwell_done;
    logic [6:0]      seg_raw;
    logic [1:0]      an_raw;

    // Next state, dwell counter, snapshot and output pattern from the current phase.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        ones_d     = ones_q;
        tens_d     = tens_q;
        seg_raw    = SEG_OFF;
        an_raw     = 2'b00;
        dwell_done = ((state_q == ONES) || (state_q == TENS)) ? (cnt_q == LitLast)
                                                              : (cnt_q == GapLast);
        if (dwell_done) begin
            cnt_d = '0;
            unique case (state_q)
                ONES:    state_d = GAP1;
                GAP1:    state_d = TENS;
                TENS:    state_d = GAP0;
                default: state_d = ONES;
            endcase
            // Frame boundary: latch both digits so a frame never mixes old and new values.
            if (state_q == GAP0) begin
                ones_d = ones;
                tens_d = tens;
            end
        end

        if (state_q == ONES) begin
            seg_raw = bcd_to_seg(ones_q);
            an_raw  = 2'b01;
        end else if ((state_q == TENS) && !(LZ_BLANK && (tens_q == 4'd0))) begin
            seg_raw = bcd_to_seg(tens_q);
            an_raw  = 2'b10;
        end

        seg_d = ACTIVE_LOW ? ~seg_raw : seg_raw;
        an_d  = ACTIVE_LOW ? ~an_raw : an_raw;
    end

    // State and registered outputs; reset parks the machine at the start of GAP0, dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GAP0;
            cnt_q   <= '0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            seg_q   <= SegDark;
            an_q    <= AnDark;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Self-checking bench: three driver instances (default, no leading-zero blanking,
// active-high pins) share stimulus and are compared every cycle against a frame model.
module tb_seg7_mux_driver;

    localparam int unsigned R = 4;
    localparam int unsigned G = 2;
    localparam int unsigned F = 2 * (R + G);

    logic       clk;
    logic       rst;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [6:0] seg_a, seg_b, seg_c;
    logic [1:0] an_a, an_b, an_c;

    int n_cmp;
    int n_bad;

    seg7_mux_driver #(
        .REFRESH_DIV(R), .GAP_CYCLES(G), .LZ_BLANK(1'b1), .ACTIVE_LOW(1'b1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .ones(ones), .tens(tens), .seg(seg_a), .an(an_a)
    );

    seg7_mux_driver #(
        .REFRESH_DIV(R), .GAP_CYCLES(G), .LZ_BLANK(1'b0), .ACTIVE_LOW(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .ones(ones), .tens(tens), .seg(seg_b), .an(an_b)
    );

    seg7_mux_driver #(
        .REFRESH_DIV(R), .GAP_CYCLES(G), .LZ_BLANK(1'b1), .ACTIVE_LOW(1'b0)
    ) u_dut_c (
        .clk(clk), .rst(rst), .ones(ones), .tens(tens), .seg(seg_c), .an(an_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent active-high glyph table {g,f,e,d,c,b,a}.
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Pins expected when the state register is at frame position pos.
    // Frame positions: [0,G) GAP0, [G,G+R) ONES, [G+R,2G+R) GAP1, [2G+R,F) TENS.
    function automatic logic [8:0] model_pins(input int pos, input logic [3:0] so,
                                              input logic [3:0] st, input bit lz,
                                              input bit al);
        logic [6:0] s;
        logic [1:0] a;
        s = 7'h00;
        a = 2'b00;
        if (pos >= G && pos < G + R) begin
            s = glyph[so];
            a = 2'b01;
        end else if (pos >= 2 * G + R && !(lz && st == 4'd0)) begin
            s = glyph[st];
            a = 2'b10;
        end
        if (al) begin
            s = ~s;
            a = ~a;
        end
        return {a, s};
    endfunction

    int         m_pos;
    logic [3:0] m_ones, m_tens;
    logic [8:0] exp_a, exp_b, exp_c;
    bit         m_valid;

    initial begin
        m_valid = 1'b0;
        m_pos   = 0;
        m_ones  = 4'd0;
        m_tens  = 4'd0;
    end

    // Frame model: advance one frame position per edge, capture digits on entering ONES.
    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_pos   = 0;
            m_ones  = 4'd0;
            m_tens  = 4'd0;
            exp_a   = {2'b11, 7'h7F};
            exp_b   = {2'b11, 7'h7F};
            exp_c   = {2'b00, 7'h00};
        end else begin
            exp_a = model_pins(m_pos, m_ones, m_tens, 1'b1, 1'b1);
            exp_b = model_pins(m_pos, m_ones, m_tens, 1'b0, 1'b1);
            exp_c = model_pins(m_pos, m_ones, m_tens, 1'b1, 1'b0);
            m_pos = (m_pos + 1) % F;
            if (m_pos == G) begin
                m_ones = ones;
                m_tens = tens;
            end
        end
    end

    // Compare every instance against the model mid-cycle, plus the one-digit-at-a-time rule.
    always @(negedge clk) begin
        if (m_valid) begin
            n_cmp++;
            if ({an_a, seg_a} !== exp_a) begin
                n_bad++;
                $display("FAIL model_a t=%0t an/seg got %b/%h want %b/%h", $time,
                         an_a, seg_a, exp_a[8:7], exp_a[6:0]);
            end
            n_cmp++;
            if ({an_b, seg_b} !== exp_b) begin
                n_bad++;
                $display("FAIL model_b t=%0t an/seg got %b/%h want %b/%h", $time,
                         an_b, seg_b, exp_b[8:7], exp_b[6:0]);
            end
            n_cmp++;
            if ({an_c, seg_c} !== exp_c) begin
                n_bad++;
                $display("FAIL model_c t=%0t an/seg got %b/%h want %b/%h", $time,
                         an_c, seg_c, exp_c[8:7], exp_c[6:0]);
            end
            n_cmp++;
            if (an_a == 2'b00 || an_b == 2'b00 || an_c == 2'b11) begin
                n_bad++;
                $display("FAIL both_digits t=%0t an_a=%b an_b=%b an_c=%b want one-hot/off",
                         $time, an_a, an_b, an_c);
            end
        end
    end

    int ed;

    // Advance to a given edge count (counted from reset release), sampling 1 unit after it.
    task automatic goto(input int target);
        while (ed < target) begin
            @(posedge clk);
            #1;
            ed++;
        end
    endtask

    task automatic chk(input string name, input logic [1:0] an_got, input logic [6:0] seg_got,
                       input logic [1:0] an_exp, input logic [6:0] seg_exp);
        n_cmp++;
        if (an_got !== an_exp || seg_got !== seg_exp) begin
            n_bad++;
            $display("FAIL %s edge=%0d an/seg got %b/%h want %b/%h", name, ed, an_got, seg_got,
                     an_exp, seg_exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ed    = 0;
        rst   = 1'b1;
        ones  = 4'd7;
        tens  = 4'd4;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset release and a steady 7/4 frame.
        goto(1);  chk("rst_e1", an_a, seg_a, 2'b11, 7'h7F);
        goto(2);  chk("rst_e2", an_a, seg_a, 2'b11, 7'h7F);
        goto(3);  chk("ones7_first", an_a, seg_a, 2'b10, 7'h78);
        chk("ones7_hi", an_c, seg_c, 2'b01, 7'h07);
        goto(6);  chk("ones7_last", an_a, seg_a, 2'b10, 7'h78);
        goto(7);  chk("gap1", an_a, seg_a, 2'b11, 7'h7F);
        goto(9);  chk("tens4_first", an_a, seg_a, 2'b01, 7'h19);
        goto(12); chk("tens4_last", an_a, seg_a, 2'b01, 7'h19);
        goto(13); chk("gap0", an_a, seg_a, 2'b11, 7'h7F);
        goto(15); chk("ones7_frame2", an_a, seg_a, 2'b10, 7'h78);

        // Tearing: ones changes mid-window, must not show until the next frame.
        ones = 4'd3;
        goto(27); chk("ones3", an_a, seg_a, 2'b10, 7'h30);
        goto(28); ones = 4'd8;
        goto(29); chk("tear_hold1", an_a, seg_a, 2'b10, 7'h30);
        goto(30); chk("tear_hold2", an_a, seg_a, 2'b10, 7'h30);
        goto(39); chk("ones8", an_a, seg_a, 2'b10, 7'h00);

        // Non-BCD code shows a dash.
        ones = 4'hC;
        goto(51); chk("dash", an_a, seg_a, 2'b10, 7'h3F);

        // Leading-zero blanking on and off.
        ones = 4'd5;
        tens = 4'd0;
        goto(63); chk("ones5", an_a, seg_a, 2'b10, 7'h12);
        goto(69); chk("lz_blank", an_a, seg_a, 2'b11, 7'h7F);
        chk("lz_show", an_b, seg_b, 2'b01, 7'h40);
        chk("lz_blank_hi", an_c, seg_c, 2'b00, 7'h00);

        // Reset during the second TENS state cycle, then restart timing.
        rst = 1'b1;
        goto(70); chk("midrst", an_b, seg_b, 2'b11, 7'h7F);
        rst = 1'b0;
        ed  = 0;
        goto(1);  chk("rst2_e1", an_b, seg_b, 2'b11, 7'h7F);
        goto(2);  chk("rst2_e2", an_b, seg_b, 2'b11, 7'h7F);
        goto(3);  chk("rst2_ones5", an_b, seg_b, 2'b10, 7'h12);

        // Randomised digits and occasional resets, checked by the frame model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 7) == 0) ones = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) tens = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) tens = 4'd0;
            if (rst) rst = ($urandom_range(0, 2) != 0);
            else     rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        repeat (2 * F) @(posedge clk);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
